// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encodings and widths.
package rst_seq_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned LOST_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/rst_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : synchronous active-low clear of both flops
//   d     : asynchronous input
//   q     : synchronised output, lags d by two clk edges
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: qualifies PLL lock, then releases NUM_CH active-low
// resets one at a time, restarting on lock loss or a software request.
//   sys_clk       : sole clock
//   sys_rst       : synchronous active-low reset
//   pll_locked    : asynchronous PLL lock indicator
//   sw_rst_req    : one-cycle software reset request (honoured in RUN only)
//   rst_n_out     : per-channel active-low resets, bit 0 released first
//   seq_done      : high while all channels are released
//   state_o       : current state encoding
//   lock_lost_cnt : saturating count of lock-loss events
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned LOCK_STABLE = 256,
  parameter int unsigned STAGE_DLY   = 1000,
  parameter int unsigned SW_RST_HOLD = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_CH-1:0]     rst_n_out,
  output logic                  seq_done,
  output logic [STATE_W-1:0]    state_o,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  seq_state_e       state;
  logic             lk_s;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] dly_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] ch_idx;

  sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .d     (pll_locked),
    .q     (lk_s)
  );

  assign state_o = state;

  // Sequencing FSM with counters and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state         <= ST_IDLE;
      stable_cnt    <= '0;
      dly_cnt       <= '0;
      hold_cnt      <= '0;
      ch_idx        <= '0;
      rst_n_out     <= '0;
      seq_done      <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_WAIT_LOCK;
          stable_cnt <= '0;
        end

        ST_WAIT_LOCK: begin
          if (!lk_s) begin
            stable_cnt <= '0;
          end else if (stable_cnt == CNT_W'(LOCK_STABLE - 1)) begin
            state      <= ST_RELEASE;
            stable_cnt <= '0;
            dly_cnt    <= '0;
            ch_idx     <= '0;
          end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
          end
        end

        ST_RELEASE, ST_RUN, ST_HOLD: begin
          if (!lk_s) begin
            // Lock loss outranks everything but sys_rst, including sw_rst_req.
            state      <= ST_WAIT_LOCK;
            stable_cnt <= '0;
            dly_cnt    <= '0;
            hold_cnt   <= '0;
            ch_idx     <= '0;
            rst_n_out  <= '0;
            seq_done   <= 1'b0;
            if (lock_lost_cnt != '1) begin
              lock_lost_cnt <= lock_lost_cnt + LOST_CNT_W'(1);
            end
          end else if (state == ST_RELEASE) begin
            if (dly_cnt == CNT_W'(STAGE_DLY - 1)) begin
              dly_cnt <= '0;
              ch_idx  <= ch_idx + IDX_W'(1);
              for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch_idx == IDX_W'(i)) begin
                  rst_n_out[i] <= 1'b1;
                end
              end
              if (ch_idx == IDX_W'(NUM_CH - 1)) begin
                state    <= ST_RUN;
                seq_done <= 1'b1;
              end
            end else begin
              dly_cnt <= dly_cnt + CNT_W'(1);
            end
          end else if (state == ST_RUN) begin
            if (sw_rst_req) begin
              state     <= ST_HOLD;
              hold_cnt  <= '0;
              rst_n_out <= '0;
              seq_done  <= 1'b0;
            end
          end else begin
            // HOLD returns straight to RELEASE; lock is not requalified.
            if (hold_cnt == CNT_W'(SW_RST_HOLD - 1)) begin
              state    <= ST_RELEASE;
              hold_cnt <= '0;
              dly_cnt  <= '0;
              ch_idx   <= '0;
            end else begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: power-up vector table, directed
// corner-case sequences and randomized stimulus against a timeline model.
module tb_rst_sequencer;

  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned LOCK_STABLE = 4;
  localparam int unsigned STAGE_DLY   = 3;
  localparam int unsigned SW_RST_HOLD = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              pll_locked;
  logic              sw_rst_req;
  logic [NUM_CH-1:0] rst_n_out;
  logic              seq_done;
  logic [2:0]        state_o;
  logic [7:0]        lock_lost_cnt;

  int checks = 0;
  int passed = 0;

  rst_sequencer #(
    .NUM_CH      (NUM_CH),
    .LOCK_STABLE (LOCK_STABLE),
    .STAGE_DLY   (STAGE_DLY),
    .SW_RST_HOLD (SW_RST_HOLD),
    .CNT_W       (16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .rst_n_out     (rst_n_out),
    .seq_done      (seq_done),
    .state_o       (state_o),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: phase plus elapsed-cycle counts; outputs derived
  // from how long the sequence has been running.
  typedef enum int {M_IDLE, M_QUAL, M_REL, M_RUN, M_HOLD} mphase_e;
  mphase_e m_phase  = M_IDLE;
  int      m_qual   = 0;
  int      m_rel    = 0;
  int      m_hold   = 0;
  int      m_losses = 0;
  bit      m_s1     = 1'b0;
  bit      m_s2     = 1'b0;

  task automatic model_step(input bit rst, input bit pll, input bit sw);
    bit lk;
    if (!rst) begin
      m_phase = M_IDLE; m_qual = 0; m_rel = 0; m_hold = 0; m_losses = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = pll;
      case (m_phase)
        M_IDLE: begin m_phase = M_QUAL; m_qual = 0; end
        M_QUAL: begin
          if (lk) begin
            m_qual++;
            if (m_qual == LOCK_STABLE) begin m_phase = M_REL; m_rel = 0; end
          end else m_qual = 0;
        end
        default: begin
          if (!lk) begin
            m_losses++; m_phase = M_QUAL; m_qual = 0;
          end else if (m_phase == M_REL) begin
            m_rel++;
            if (m_rel == NUM_CH * STAGE_DLY) m_phase = M_RUN;
          end else if (m_phase == M_RUN) begin
            if (sw) begin m_phase = M_HOLD; m_hold = 0; end
          end else begin
            m_hold++;
            if (m_hold == SW_RST_HOLD) begin m_phase = M_REL; m_rel = 0; end
          end
        end
      endcase
    end
  endtask

  function automatic int exp_state();
    case (m_phase)
      M_IDLE:  return 0;
      M_QUAL:  return 1;
      M_REL:   return 2;
      M_RUN:   return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int exp_rst_n();
    int k;
    int m;
    k = 0;
    if (m_phase == M_RUN) k = NUM_CH;
    else if (m_phase == M_REL) k = m_rel / STAGE_DLY;
    m = 0;
    for (int i = 0; i < k; i++) m = m | (1 << i);
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive inputs, step model on the edge, compare 1 time unit later.
  task automatic tick(input bit rst, input bit pll, input bit sw);
    sys_rst    = rst;
    pll_locked = pll;
    sw_rst_req = sw;
    @(posedge sys_clk);
    model_step(rst, pll, sw);
    #1;
    chk("model_state", int'(state_o), exp_state());
    chk("model_rst_n", int'(rst_n_out), exp_rst_n());
    chk("model_done", int'(seq_done), (m_phase == M_RUN) ? 1 : 0);
    chk("model_lost", int'(lock_lost_cnt), (m_losses > 255) ? 255 : m_losses);
  endtask

  task automatic wait_state(input int code, input bit pll, input int maxc);
    int n;
    n = 0;
    while (int'(state_o) != code && n < maxc) begin
      tick(1'b1, pll, 1'b0);
      n++;
    end
    chk("wait_state", int'(state_o), code);
  endtask

  typedef struct {
    bit rst; bit pll; bit sw;
    int st; int rn; int dn; int lc;
  } vec_t;

  function automatic vec_t mk(bit rst, int st, int rn, int dn);
    vec_t v;
    v.rst = rst; v.pll = 1'b1; v.sw = 1'b0;
    v.st = st; v.rn = rn; v.dn = dn; v.lc = 0;
    return v;
  endfunction

  vec_t tv[19];

  initial begin
    int  n;
    bit  pll_r;

    sys_rst = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b0;

    // Power-up vectors: 5 reset edges, then qualification and staggered release.
    for (int i = 0; i < 5; i++) tv[i] = mk(1'b0, 0, 0, 0);
    for (int i = 5; i < 10; i++) tv[i] = mk(1'b1, 1, 0, 0);
    tv[10] = mk(1'b1, 2, 0, 0);
    tv[11] = mk(1'b1, 2, 0, 0);
    tv[12] = mk(1'b1, 2, 0, 0);
    tv[13] = mk(1'b1, 2, 1, 0);
    tv[14] = mk(1'b1, 2, 1, 0);
    tv[15] = mk(1'b1, 2, 1, 0);
    tv[16] = mk(1'b1, 3, 3, 1);
    tv[17] = mk(1'b1, 3, 3, 1);
    tv[18] = mk(1'b1, 3, 3, 1);
    for (int i = 0; i < 19; i++) begin
      tick(tv[i].rst, tv[i].pll, tv[i].sw);
      chk("tbl_state", int'(state_o), tv[i].st);
      chk("tbl_rst_n", int'(rst_n_out), tv[i].rn);
      chk("tbl_done", int'(seq_done), tv[i].dn);
      chk("tbl_lost", int'(lock_lost_cnt), tv[i].lc);
    end

    // Lock glitch during qualification.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    n = 0;
    do begin
      tick(1'b1, 1'b1, 1'b0);
      n++;
    end while (int'(state_o) != 2 && n < 20);
    chk("glitch_latency", n, 6);
    chk("glitch_lost", int'(lock_lost_cnt), 0);

    // Lock loss in RUN, then relock.
    wait_state(3, 1'b1, 40);
    tick(1'b1, 1'b0, 1'b0);
    chk("loss_d0_state", int'(state_o), 3);
    tick(1'b1, 1'b0, 1'b0);
    chk("loss_d1_state", int'(state_o), 3);
    tick(1'b1, 1'b0, 1'b0);
    chk("loss_state", int'(state_o), 1);
    chk("loss_rst_n", int'(rst_n_out), 0);
    chk("loss_done", int'(seq_done), 0);
    chk("loss_cnt", int'(lock_lost_cnt), 1);
    wait_state(3, 1'b1, 40);
    chk("relock_rst_n", int'(rst_n_out), 3);
    chk("relock_done", int'(seq_done), 1);

    // Software reset in RUN, with an ignored request during RELEASE.
    tick(1'b1, 1'b1, 1'b1);
    chk("sw_state", int'(state_o), 4);
    chk("sw_rst_n", int'(rst_n_out), 0);
    chk("sw_done", int'(seq_done), 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("sw_hold1", int'(state_o), 4);
    tick(1'b1, 1'b1, 1'b0);
    chk("sw_release", int'(state_o), 2);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("sw_ignored_state", int'(state_o), 2);
    chk("sw_ignored_rst_n", int'(rst_n_out), 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("sw_stage1", int'(rst_n_out), 1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("sw_stage1_hold", int'(rst_n_out), 1);
    tick(1'b1, 1'b1, 1'b0);
    chk("sw_stage2", int'(rst_n_out), 3);
    chk("sw_stage2_state", int'(state_o), 3);
    chk("sw_stage2_done", int'(seq_done), 1);

    // Simultaneous software request and synchronised lock loss.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    chk("simul_state", int'(state_o), 1);
    chk("simul_cnt", int'(lock_lost_cnt), 2);

    // Saturation of the loss counter, then reset during RELEASE.
    for (int i = 0; i < 260; i++) begin
      wait_state(2, 1'b1, 30);
      wait_state(1, 1'b0, 10);
    end
    chk("sat_cnt", int'(lock_lost_cnt), 255);
    wait_state(2, 1'b1, 30);
    tick(1'b0, 1'b1, 1'b0);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_rst_n", int'(rst_n_out), 0);
    chk("midrst_cnt", int'(lock_lost_cnt), 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("midrst_resume", int'(state_o), 1);

    // Randomized traffic checked against the model every cycle.
    pll_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (pll_r) pll_r = ($urandom_range(0, 59) != 0);
      else       pll_r = ($urandom_range(0, 3) == 0);
      tick(($urandom_range(0, 499) != 0), pll_r, ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised reset sequencer between the system PLL and the Qsys/audio subsystems.
- Waits for a stable PLL lock, then releases NUM_CH active-low subsystem resets one at a time, STAGE_DLY cycles apart.
- Re-enters the sequence on PLL lock loss or a software reset request, and counts lock-loss events for debug.
- Successor to the fixed PLL-plus-system top: it adds lock qualification, staggered multi-channel reset and restart handling.

Parameters:
- NUM_CH, 4: number of reset channels (>=1).
- LOCK_STABLE, 256: consecutive synchronised pll_locked-high cycles required before release (>=1).
- STAGE_DLY, 1000: cycles between successive channel releases (>=1).
- SW_RST_HOLD, 16: cycles all channels are held in reset after a software request (>=1).
- CNT_W, 16: width of the internal delay counters; must hold max(LOCK_STABLE, STAGE_DLY, SW_RST_HOLD).

Ports:
- sys_clk, input, 1: sole clock; all logic is on its rising edge.
- sys_rst, input, 1: synchronous active-low reset.
- pll_locked, input, 1: PLL lock indicator; asynchronous, synchronised internally.
- sw_rst_req, input, 1: single-cycle software reset request, synchronous to sys_clk.
- rst_n_out, output, NUM_CH: per-channel active-low reset; bit 0 is released first.
- seq_done, output, 1: high while every channel is released (RUN state).
- state_o, output, 3: current state encoding, for debug.
- lock_lost_cnt, output, 8: count of lock-loss events; saturates at 255.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-low, on sys_rst.
- While sys_rst=0 at a clock edge:
  - rst_n_out=0, seq_done=0, state_o=IDLE(0), lock_lost_cnt=0.
  - All counters and ch_idx are 0.
  - The synchroniser flops are 0.
- Reset mid-operation aborts everything on that edge.
- Synchroniser: pll_locked passes through 2 flops; lk_s denotes the synchronised value, which lags pll_locked by 2 cycles.
- All outputs are registered.
- State encodings: IDLE=0, WAIT_LOCK=1, RELEASE=2, RUN=3, HOLD=4.
- IDLE: moves unconditionally to WAIT_LOCK on the next edge.
- WAIT_LOCK:
  - stable_cnt increments each cycle lk_s=1 and clears to 0 when lk_s=0.
  - When lk_s=1 and stable_cnt==LOCK_STABLE-1, go to RELEASE with dly_cnt=0 and ch_idx=0.
  - Net effect: RELEASE is entered after exactly LOCK_STABLE consecutive high samples.
- RELEASE:
  - dly_cnt counts 0..STAGE_DLY-1.
  - When it equals STAGE_DLY-1: set rst_n_out[ch_idx]=1, clear dly_cnt, increment ch_idx.
  - Releasing channel NUM_CH-1 moves to RUN and sets seq_done=1 on the same edge.
  - Channel k rises exactly STAGE_DLY*(k+1) cycles after the first RELEASE cycle.
  - Released channels stay high; unreleased channels stay low.
- RUN: holds all outputs. sw_rst_req=1 moves to HOLD and clears all rst_n_out and seq_done on that edge.
- HOLD:
  - hold_cnt counts 0..SW_RST_HOLD-1, then the FSM enters RELEASE with dly_cnt=0 and ch_idx=0.
  - PLL lock is not requalified.
- Lock loss: lk_s=0 while in RELEASE, RUN or HOLD causes, on that edge:
  - rst_n_out=0 and seq_done=0;
  - lock_lost_cnt increments (saturating at 255);
  - move to WAIT_LOCK with stable_cnt=0.
- Priority: sys_rst, then lock loss, then sw_rst_req, then normal sequencing.
  - sw_rst_req coinciding with lock loss counts only as a lock loss.
- sw_rst_req in IDLE, WAIT_LOCK, RELEASE or HOLD is ignored (no queuing).
- A lock glitch shorter than LOCK_STABLE cycles during WAIT_LOCK restarts qualification and is not counted.
- Counters never wrap: each is compared against a limit and cleared.

Decomposition:
- Shared package/include (rst_seq_pkg): the state encodings IDLE..HOLD, state width 3, LOST_CNT_W=8.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with synchronous active-low clear, used for pll_locked.
- The FSM, the counters and rst_n_out generation stay in rst_sequencer.

Test Plan (bench parameters NUM_CH=2, LOCK_STABLE=4, STAGE_DLY=3, SW_RST_HOLD=2 unless noted):
- Power-up: sys_rst low 5 cycles then high, pll_locked=1 throughout.
  - Required: state_o passes 0 then 1, then reaches 2 after the synchroniser delay plus 4 cycles.
  - Required: rst_n_out goes 00, then 01 3 cycles after RELEASE entry, then 11 3 cycles later, with seq_done=1 on the same edge.
- Lock glitch in WAIT_LOCK: pll_locked high 3 cycles, low 1, high again.
  - Required: RELEASE is entered only after 4 further consecutive high samples; lock_lost_cnt stays 0.
- Lock loss in RUN: pll_locked drops.
  - Required: 2 cycles later rst_n_out=00, seq_done=0, state_o=1, lock_lost_cnt=1.
  - Required: the full sequence repeats after relock.
- Software reset in RUN: one-cycle sw_rst_req.
  - Required: next edge rst_n_out=00, state_o=4.
  - Required: RELEASE 2 cycles later, then the 01 to 11 staggering as above. A sw_rst_req asserted during RELEASE has no effect.
- Simultaneous sw_rst_req and lk_s falling in RUN.
  - Required: state_o=1 (not 4), lock_lost_cnt increments by 1.
- Saturation and reset mid-operation: force 260 lock losses, then sys_rst low during RELEASE.
  - Required: lock_lost_cnt holds at 255.
  - Required: the reset edge gives rst_n_out=00, state_o=0, lock_lost_cnt=0.
